link_order_master: RTL and testbench
====================================

Name: link_order_master

Overview:
- Initiator for the linked-list engine's order/dout interface; sits upstream of link_top and drives its order port.
- Buffers host commands in a FIFO and issues them as orders, honouring order_busy.
- Tracks outstanding READs with a tag FIFO and returns each dout_data to the host, tagged with the table/node that requested it.

Parameters:
ADDR_WIDTH, 16, node address width (order_node)
DATA_WIDTH, 16, payload width (order_data, dout_data)
TABLE_WIDTH, 8, table index width (order_table)
CMD_DEPTH, 4, host command FIFO depth (power of 2, >=2)
MAX_RD, 4, maximum outstanding READ orders (power of 2, >=1)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  host command valid
cmd_ready  out  1  command FIFO not full
cmd_type  in  2  00 APPE, 01 DELE, 10 CHAG, 11 READ
cmd_table  in  TABLE_WIDTH  target table
cmd_node  in  ADDR_WIDTH  target node/place
cmd_data  in  DATA_WIDTH  write data (ignored for DELE/READ)
order_valid  out  1  order request
order_busy  in  1  engine stall
order_type  out  2  issued type
order_table  out  TABLE_WIDTH  issued table
order_node  out  ADDR_WIDTH  issued node
order_data  out  DATA_WIDTH  issued data (0 for DELE/READ)
dout_valid  in  1  read data valid
dout_busy  out  1  read data stall
dout_data  in  DATA_WIDTH  read data
rsp_valid  out  1  host response valid
rsp_ready  in  1  host response accept
rsp_data  out  DATA_WIDTH  read result
rsp_table  out  TABLE_WIDTH  table of originating READ
rsp_node  out  ADDR_WIDTH  node of originating READ
rd_pending  out  $clog2(MAX_RD)+1  outstanding READ count
err_unexp  out  1  sticky: dout arrived with no outstanding READ

Behaviour:
- Reset: async on rst_n low. All outputs 0, both FIFOs empty, FSM IDLE, rd_pending 0, err_unexp 0. cmd_ready rises on the first clock after release. Reset mid-order drops order_valid immediately; the in-flight order is abandoned.
- Transfer rules: host cmd accepted on an edge with cmd_valid&cmd_ready. Order accepted on an edge with order_valid&!order_busy. Dout accepted on an edge with dout_valid&!dout_busy. Rsp consumed on an edge with rsp_valid&rsp_ready.
- Order stability: order_* are registers, held stable while order_valid=1 and not yet accepted.
- FSM IDLE: if the command FIFO is non-empty and eligible, pop it, load the order regs, assert order_valid, and go to ISSUE.
  - Eligible = type!=READ or rd_pending<MAX_RD.
  - For DELE/READ, order_data is forced to 0.
- FSM ISSUE: hold until the order is accepted. On acceptance, if the next FIFO head is eligible, reload in the same edge (back-to-back, order_valid stays 1); else deassert order_valid and go to IDLE.
- Latency: command accepted at edge N, empty pipe → order_valid high after edge N+1. Steady-state throughput is 1 order/cycle with order_busy=0.
- READ tracking: loading a READ pushes {table,node} into the tag FIFO and increments rd_pending (reservation at load, not at acceptance).
  - Accepted dout pops the tag and decrements rd_pending.
  - Simultaneous load-READ and dout accept: count unchanged; tag push and pop both occur.
- Response register (single entry):
  - Loads {dout_data, tag} on dout accept; rsp_valid=1.
  - Clears when consumed, unless reloaded the same edge.
  - dout_busy = rsp_valid & !rsp_ready (combinational); no data loss.
- Unexpected dout (rd_pending=0): accepted (dout_busy low), data dropped, err_unexp set until reset, rsp_valid unchanged.
- Command FIFO: full → cmd_ready=0. A push on an empty FIFO is visible to the FSM the next cycle (no fall-through). Pointers wrap modulo CMD_DEPTH.
- Type ordering: orders issue strictly in command order; a blocked READ at the head stalls all following commands (no reordering).

Optional Feature:
- Macro: LINK_ORDER_STATS_EN.
- Defined: adds output ports stat_appe, stat_dele, stat_chag, stat_read (each 16 bits). Each counts accepted orders of its type, saturates at 0xFFFF, and resets to 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package link_pkg: type localparams APPE=2'b00, DELE=2'b01, CHAG=2'b10, READ=2'b11; FSM state enum {IDLE, ISSUE}; packed tag struct {table, node}.
- Sub-module link_sync_fifo (parameterised WIDTH/DEPTH, push/pop/full/empty/count), instantiated twice: command FIFO and tag FIFO.

Test Plan:
- Basic issue: APPE(3,1,111), APPE(3,2,112), APPE(3,3,113), DELE(3,3), APPE(1,3,20) with order_busy=0 → five orders in order, back-to-back, DELE order_data=0, rd_pending stays 0.
- Busy stall: order_busy held 1 for 5 cycles during APPE(3,2,112) → order fields stable all 5 cycles, single transfer on release, cmd_ready=0 once 4 more commands are queued.
- Read return: READ(3,2), engine returns dout 112 three cycles later → rsp_valid with rsp_data=112, rsp_table=3, rsp_node=2, rd_pending 1→0.
- Read credit limit: 5 READs, no dout → 4 issued, 5th held in FIFO, rd_pending=4. One dout returned → 5th issues next edge.
- Response backpressure: rsp_ready=0 with rsp_valid=1 and a second dout presented → dout_busy=1, dout_data held. rsp_ready=1 → both responses delivered in order.
- Error and reset: dout_valid with rd_pending=0 → err_unexp=1, no rsp. rst_n pulsed low while order_valid=1 → order_valid 0 immediately, FIFOs empty, err_unexp 0.

Source files
------------

// File: rtl/link_pkg.sv
// link_pkg: order types, FSM states and READ tag layout shared by the link order master.
package link_pkg;
  localparam logic [1:0] APPE = 2'b00;
  localparam logic [1:0] DELE = 2'b01;
  localparam logic [1:0] CHAG = 2'b10;
  localparam logic [1:0] READ = 2'b11;
  localparam int LINK_TABLE_W = 8;
  localparam int LINK_ADDR_W = 16;
  typedef enum logic {IDLE, ISSUE} state_e;
  typedef struct packed {
    logic [LINK_TABLE_W-1:0] tbl;
    logic [LINK_ADDR_W-1:0]  node;
  } tag_t;
endpackage

// File: rtl/link_sync_fifo.sv
// link_sync_fifo: registered FIFO with occupancy count; the head is readable without fall-through.
module link_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign full  = cnt_q == CW'(DEPTH);
  assign empty = cnt_q == '0;
  assign count = cnt_q;
  assign dout  = mem_q[rd_q];
  always_comb begin
    do_push = push && !full;
    do_pop  = pop && !empty;
    wr_d    = do_push ? (wr_q == AW'(DEPTH - 1) ? '0 : wr_q + 1'b1) : wr_q;
    rd_d    = do_pop ? (rd_q == AW'(DEPTH - 1) ? '0 : rd_q + 1'b1) : rd_q;
    cnt_d   = cnt_q + CW'(do_push) - CW'(do_pop);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end
endmodule

// File: rtl/link_order_master.sv
// link_order_master: queues host commands, issues them as engine orders and routes READ data back tagged.
// Optional LINK_ORDER_STATS_EN adds saturating per-type counters of accepted orders.
module link_order_master
  import link_pkg::*;
#(
  parameter int ADDR_WIDTH  = LINK_ADDR_W,
  parameter int DATA_WIDTH  = 16,
  parameter int TABLE_WIDTH = LINK_TABLE_W,
  parameter int CMD_DEPTH   = 4,
  parameter int MAX_RD      = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [1:0]                 cmd_type,
  input  logic [TABLE_WIDTH-1:0]     cmd_table,
  input  logic [ADDR_WIDTH-1:0]      cmd_node,
  input  logic [DATA_WIDTH-1:0]      cmd_data,
  output logic                       order_valid,
  input  logic                       order_busy,
  output logic [1:0]                 order_type,
  output logic [TABLE_WIDTH-1:0]     order_table,
  output logic [ADDR_WIDTH-1:0]      order_node,
  output logic [DATA_WIDTH-1:0]      order_data,
  input  logic                       dout_valid,
  output logic                       dout_busy,
  input  logic [DATA_WIDTH-1:0]      dout_data,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [DATA_WIDTH-1:0]      rsp_data,
  output logic [TABLE_WIDTH-1:0]     rsp_table,
  output logic [ADDR_WIDTH-1:0]      rsp_node,
  output logic [$clog2(MAX_RD):0]    rd_pending,
  output logic                       err_unexp
`ifdef LINK_ORDER_STATS_EN
  ,
  output logic [15:0]                stat_appe,
  output logic [15:0]                stat_dele,
  output logic [15:0]                stat_chag,
  output logic [15:0]                stat_read
`endif
);
  localparam int CW = 2 + TABLE_WIDTH + ADDR_WIDTH + DATA_WIDTH;
  localparam int RW = $clog2(MAX_RD) + 1;
  state_e state_q, state_d;
  logic ready_q;
  logic [1:0] type_q, type_d;
  logic [TABLE_WIDTH-1:0] table_q, table_d;
  logic [ADDR_WIDTH-1:0] node_q, node_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic rsp_valid_q, rsp_valid_d, err_q, err_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  tag_t rsp_tag_q, rsp_tag_d, tag_in, tag_out;
  logic [CW-1:0] cmd_head;
  logic [1:0] head_type;
  logic [TABLE_WIDTH-1:0] head_table;
  logic [ADDR_WIDTH-1:0] head_node;
  logic [DATA_WIDTH-1:0] head_data;
  logic cmd_full, cmd_empty, tag_full, tag_empty;
  logic [$clog2(CMD_DEPTH):0] cmd_count;
  logic order_acc, eligible, load, rd_load, dout_acc, dout_exp;
  logic unused_fifo;
  assign unused_fifo = ^{cmd_count, tag_full, tag_empty};
  assign {head_type, head_table, head_node, head_data} = cmd_head;
  assign cmd_ready   = ready_q && !cmd_full;
  assign order_valid = state_q == ISSUE;
  assign order_type  = type_q;
  assign order_table = table_q;
  assign order_node  = node_q;
  assign order_data  = data_q;
  assign dout_busy   = rsp_valid_q && !rsp_ready;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_table   = rsp_tag_q.tbl;
  assign rsp_node    = rsp_tag_q.node;
  assign err_unexp   = err_q;
  link_sync_fifo #(.WIDTH(CW), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk(clk), .rst_n(rst_n),
    .push(cmd_valid && cmd_ready), .din({cmd_type, cmd_table, cmd_node, cmd_data}),
    .pop(load), .dout(cmd_head), .full(cmd_full), .empty(cmd_empty), .count(cmd_count)
  );
  // Tag occupancy doubles as the outstanding-READ count: both move on READ load and on expected dout.
  link_sync_fifo #(.WIDTH($bits(tag_t)), .DEPTH(MAX_RD)) u_tag_fifo (
    .clk(clk), .rst_n(rst_n),
    .push(rd_load), .din(tag_in), .pop(dout_exp), .dout(tag_out),
    .full(tag_full), .empty(tag_empty), .count(rd_pending)
  );
  always_comb begin
    order_acc   = order_valid && !order_busy;
    eligible    = !cmd_empty && (head_type != READ || rd_pending < RW'(MAX_RD));
    load        = eligible && (state_q == IDLE || order_acc);
    rd_load     = load && head_type == READ;
    tag_in      = '{tbl: head_table, node: head_node};
    state_d     = load ? ISSUE : order_acc ? IDLE : state_q;
    type_d      = load ? head_type : type_q;
    table_d     = load ? head_table : table_q;
    node_d      = load ? head_node : node_q;
    data_d      = load ? (head_type == DELE || head_type == READ ? '0 : head_data) : data_q;
    dout_acc    = dout_valid && !dout_busy;
    dout_exp    = dout_acc && rd_pending != '0;
    err_d       = err_q || (dout_acc && rd_pending == '0);
    rsp_valid_d = dout_exp || (rsp_valid_q && !rsp_ready);
    rsp_data_d  = dout_exp ? dout_data : rsp_data_q;
    rsp_tag_d   = dout_exp ? tag_out : rsp_tag_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ready_q     <= 1'b0;
      type_q      <= '0;
      table_q     <= '0;
      node_q      <= '0;
      data_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_tag_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ready_q     <= 1'b1;
      type_q      <= type_d;
      table_q     <= table_d;
      node_q      <= node_d;
      data_q      <= data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_tag_q   <= rsp_tag_d;
      err_q       <= err_d;
    end
  end
`ifdef LINK_ORDER_STATS_EN
  logic [3:0][15:0] stat_q, stat_d;
  always_comb begin
    stat_d = stat_q;
    if (order_acc && stat_q[type_q] != 16'hFFFF) stat_d[type_q] = stat_q[type_q] + 16'd1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stat_q <= '0;
    else        stat_q <= stat_d;
  end
  assign stat_appe = stat_q[APPE];
  assign stat_dele = stat_q[DELE];
  assign stat_chag = stat_q[CHAG];
  assign stat_read = stat_q[READ];
`endif
endmodule

// File: tb/tb_link_order_master.sv
// tb_link_order_master: directed checks of command issue, stalls, READ credit/tag return, errors and reset.
module tb_link_order_master;
  import link_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0;
  logic cmd_valid = 0, cmd_ready, order_valid, order_busy = 0, dout_valid = 0, dout_busy;
  logic rsp_valid, rsp_ready = 0, err_unexp;
  logic [1:0] cmd_type = 0, order_type;
  logic [7:0] cmd_table = 0, order_table, rsp_table;
  logic [15:0] cmd_node = 0, cmd_data = 0, order_node, order_data, dout_data = 0, rsp_data, rsp_node;
  logic [2:0] rd_pending;
`ifdef LINK_ORDER_STATS_EN
  logic [15:0] stat_appe, stat_dele, stat_chag, stat_read;
`endif
  int checks = 0, failures = 0, cyc = 0;
  logic [63:0] olog[$], rlog[$];
  int ocyc[$];
  link_order_master dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
    .cmd_table(cmd_table), .cmd_node(cmd_node), .cmd_data(cmd_data), .order_valid(order_valid),
    .order_busy(order_busy), .order_type(order_type), .order_table(order_table), .order_node(order_node),
    .order_data(order_data), .dout_valid(dout_valid), .dout_busy(dout_busy), .dout_data(dout_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_table(rsp_table),
    .rsp_node(rsp_node), .rd_pending(rd_pending), .err_unexp(err_unexp)
`ifdef LINK_ORDER_STATS_EN
    , .stat_appe(stat_appe), .stat_dele(stat_dele), .stat_chag(stat_chag), .stat_read(stat_read)
`endif
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (rst_n && order_valid && !order_busy) begin
      olog.push_back({22'd0, order_type, order_table, order_node, order_data});
      ocyc.push_back(cyc);
    end
    if (rst_n && rsp_valid && rsp_ready) rlog.push_back({24'd0, rsp_data, rsp_table, rsp_node});
  end
  function automatic logic [63:0] ord(logic [1:0] t, logic [7:0] tb, logic [15:0] n, logic [15:0] d);
    return {22'd0, t, tb, n, d};
  endfunction
  function automatic logic [63:0] rsp(logic [15:0] d, logic [7:0] tb, logic [15:0] n);
    return {24'd0, d, tb, n};
  endfunction
  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(logic [1:0] t, logic [7:0] tb, logic [15:0] n, logic [15:0] d);
    int w = 0;
    cmd_valid = 1; cmd_type = t; cmd_table = tb; cmd_node = n; cmd_data = d;
    while (!cmd_ready && w < 50) begin tick(); w++; end
    if (w == 50) check("send_timeout", cmd_ready, 1);
    tick();
    cmd_valid = 0;
  endtask
  task automatic wait_ov();
    int w = 0;
    while (!order_valid && w < 50) begin tick(); w++; end
    if (w == 50) check("order_timeout", order_valid, 1);
  endtask
  function automatic logic [63:0] cur();
    return ord(order_type, order_table, order_node, order_data);
  endfunction
  initial begin
    int ob, rb;
    logic [63:0] e1 [5];
    tick(); tick();
    check("rst_order_valid", order_valid, 0);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rd_pending", rd_pending, 0);
    check("rst_err", err_unexp, 0);
    rst_n = 1;
    check("rel_cmd_ready_low", cmd_ready, 0);
    tick();
    check("rel_cmd_ready_high", cmd_ready, 1);
    // basic back-to-back issue
    e1[0] = ord(APPE, 3, 1, 111); e1[1] = ord(APPE, 3, 2, 112); e1[2] = ord(APPE, 3, 3, 113);
    e1[3] = ord(DELE, 3, 3, 0);   e1[4] = ord(APPE, 1, 3, 20);
    ob = olog.size();
    send(APPE, 3, 1, 111); send(APPE, 3, 2, 112); send(APPE, 3, 3, 113);
    send(DELE, 3, 3, 55); send(APPE, 1, 3, 20);
    repeat (4) tick();
    check("basic_count", olog.size() - ob, 5);
    for (int i = 0; i < 5 && ob + i < olog.size(); i++) begin
      check($sformatf("basic_order%0d", i), olog[ob + i], e1[i]);
      check($sformatf("basic_b2b%0d", i), ocyc[ob + i] - ocyc[ob], i);
    end
    check("basic_rd_pending", rd_pending, 0);
    // busy stall
    order_busy = 1;
    ob = olog.size();
    send(APPE, 3, 2, 112);
    wait_ov();
    check("stall_first", cur(), ord(APPE, 3, 2, 112));
    send(CHAG, 2, 5, 55); check("stall_hold1", cur(), ord(APPE, 3, 2, 112));
    send(APPE, 2, 6, 66); check("stall_hold2", cur(), ord(APPE, 3, 2, 112));
    send(DELE, 2, 7, 99); check("stall_hold3", cur(), ord(APPE, 3, 2, 112));
    send(CHAG, 2, 8, 88); check("stall_hold4", cur(), ord(APPE, 3, 2, 112));
    check("stall_full", cmd_ready, 0);
    tick();
    check("stall_hold5", {order_valid, cur()}, {1'b1, ord(APPE, 3, 2, 112)});
    check("stall_no_xfer", olog.size() - ob, 0);
    order_busy = 0;
    tick();
    check("stall_single_xfer", olog.size() - ob, 1);
    if (olog.size() > ob) check("stall_xfer_val", olog[ob], ord(APPE, 3, 2, 112));
    check("stall_ready_back", cmd_ready, 1);
    repeat (6) tick();
    check("stall_drain", olog.size() - ob, 5);
    if (olog.size() > ob + 3) check("stall_dele_data", olog[ob + 3], ord(DELE, 2, 7, 0));
    // READ return
    ob = olog.size();
    send(READ, 3, 2, 77);
    wait_ov();
    check("read_pending1", rd_pending, 1);
    repeat (3) tick();
    dout_valid = 1; dout_data = 112;
    check("read_dout_busy", dout_busy, 0);
    tick();
    dout_valid = 0;
    check("read_rsp_valid", rsp_valid, 1);
    check("read_rsp", rsp(rsp_data, rsp_table, rsp_node), rsp(112, 3, 2));
    check("read_pending0", rd_pending, 0);
    if (olog.size() > ob) check("read_order_data0", olog[ob], ord(READ, 3, 2, 0));
    rsp_ready = 1; rb = rlog.size();
    tick();
    check("read_rsp_cleared", rsp_valid, 0);
    check("read_rsp_count", rlog.size() - rb, 1);
    rsp_ready = 0;
    // READ credit limit
    ob = olog.size();
    for (int k = 1; k <= 5; k++) send(READ, 4, 16'(k), 16'(k));
    repeat (3) tick();
    check("credit_pending4", rd_pending, 4);
    check("credit_issued4", olog.size() - ob, 4);
    check("credit_blocked", order_valid, 0);
    dout_valid = 1; dout_data = 500;
    tick();
    dout_valid = 0;
    check("credit_pending3", rd_pending, 3);
    check("credit_rsp", rsp(rsp_data, rsp_table, rsp_node), rsp(500, 4, 1));
    tick();
    check("credit_fifth", {order_valid, order_node, 13'd0, rd_pending}, {1'b1, 16'd5, 13'd0, 3'd4});
    tick();
    check("credit_issued5", olog.size() - ob, 5);
    // response backpressure
    dout_valid = 1; dout_data = 600;
    #1;
    check("bp_busy", dout_busy, 1);
    tick();
    check("bp_busy_held", dout_busy, 1);
    check("bp_rsp_held", rsp_data, 500);
    check("bp_pending", rd_pending, 4);
    rsp_ready = 1; rb = rlog.size();
    #1;
    check("bp_release", dout_busy, 0);
    tick(); dout_data = 601;
    tick(); dout_data = 602;
    tick(); dout_data = 603;
    tick(); dout_valid = 0;
    tick();
    check("bp_rsp_count", rlog.size() - rb, 5);
    if (rlog.size() >= rb + 5) begin
      check("bp_rsp0", rlog[rb], rsp(500, 4, 1));
      check("bp_rsp1", rlog[rb + 1], rsp(600, 4, 2));
      check("bp_rsp4", rlog[rb + 4], rsp(603, 4, 5));
    end
    check("bp_pending0", rd_pending, 0);
    check("bp_rsp_idle", rsp_valid, 0);
    // unexpected dout
    rb = rlog.size();
    dout_valid = 1; dout_data = 999;
    #1;
    check("err_dout_busy", dout_busy, 0);
    tick();
    dout_valid = 0;
    check("err_set", err_unexp, 1);
    check("err_no_rsp", rsp_valid, 0);
    tick();
    check("err_sticky", {err_unexp, 15'd0, rlog.size() - rb}, {1'b1, 15'd0, 32'd0});
    // reset mid-order
    order_busy = 1;
    send(APPE, 9, 9, 9); send(CHAG, 9, 10, 10);
    wait_ov();
    check("mid_order_valid", order_valid, 1);
    #2 rst_n = 0;
    #1;
    check("mid_rst_order_valid", order_valid, 0);
    check("mid_rst_err", err_unexp, 0);
    check("mid_rst_cmd_ready", cmd_ready, 0);
    check("mid_rst_pending", rd_pending, 0);
    tick();
    rst_n = 1;
    tick();
    check("mid_rel_ready", cmd_ready, 1);
    order_busy = 0;
    tick(); tick();
    check("mid_fifo_empty", order_valid, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
